// File: rtl/bus_control_sequencer.sv
// Hardwired fetch/decode/execute control-step sequencer for the single-bus datapath.
// Optional feature macro MEM_WAIT_EN: adds mem_ready and holds T1 until memory responds.
module bus_control_sequencer #(
  parameter int SEL_W     = 5,
  parameter int NONE_CODE = 31
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      ir,
`ifdef MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic [SEL_W-1:0] src_sel,
  output logic             MARin,
  output logic             PCin,
  output logic             IncPC,
  output logic             Read,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             HIin,
  output logic             LOin,
  output logic             Rin,
  output logic [3:0]       rin_sel,
  output logic [4:0]       alu_op,
  output logic             busy,
  output logic             err
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_ERR
  } state_t;

  typedef struct packed {
    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
  } fields_t;

  typedef struct packed {
    logic [SEL_W-1:0] src;
    logic             mar;
    logic             pcin;
    logic             incpc;
    logic             read;
    logic             mdrin;
    logic             irin;
    logic             yin;
    logic             zin;
    logic             hiin;
    logic             loin;
    logic             rin;
    logic [3:0]       rin_sel;
    logic [4:0]       alu_op;
    logic             busy;
    logic             err;
  } ctrl_t;

  localparam logic [SEL_W-1:0] SEL_NONE  = SEL_W'(NONE_CODE);
  localparam logic [SEL_W-1:0] SRC_ZHIGH = SEL_W'(18);
  localparam logic [SEL_W-1:0] SRC_ZLOW  = SEL_W'(19);
  localparam logic [SEL_W-1:0] SRC_PC    = SEL_W'(20);
  localparam logic [SEL_W-1:0] SRC_MDR   = SEL_W'(21);
  localparam logic [SEL_W-1:0] SRC_CSIGN = SEL_W'(23);
  localparam logic [4:0]       OP_ADD    = 5'h00;

  state_t  state_q, state_d;
  fields_t fields_q, fields_d;
  ctrl_t   ctrl_q, ctrl_d;

  // Low IR bits carry the immediate, which this block never inspects.
  logic unused_ir;
  assign unused_ir = ^ir[14:0];

  function automatic logic is_itype(input logic [4:0] op);
    return (op >= 5'h0C) && (op <= 5'h0E);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == 5'h0F) || (op == 5'h10);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return (op <= 5'h0A) || is_itype(op) || is_muldiv(op);
  endfunction

  function automatic ctrl_t decode(input state_t s, input fields_t f);
    ctrl_t c;
    c      = '0;
    c.src  = SEL_NONE;
    c.busy = (s != S_IDLE) && (s != S_ERR);
    case (s)
      S_T0: begin
        c.src    = SRC_PC;
        c.mar    = 1'b1;
        c.incpc  = 1'b1;
        c.zin    = 1'b1;
        c.alu_op = OP_ADD;
      end
      S_T1: begin
        c.src   = SRC_ZLOW;
        c.pcin  = 1'b1;
        c.read  = 1'b1;
        c.mdrin = 1'b1;
      end
      S_T2: begin
        c.src  = SRC_MDR;
        c.irin = 1'b1;
      end
      S_T3: begin
        c.src = SEL_W'(f.rb);
        c.yin = is_legal(f.opcode);
      end
      S_T4: begin
        c.src    = is_itype(f.opcode) ? SRC_CSIGN : SEL_W'(f.rc);
        c.zin    = 1'b1;
        c.alu_op = f.opcode;
      end
      S_T5: begin
        c.src = SRC_ZLOW;
        if (is_muldiv(f.opcode)) begin
          c.loin = 1'b1;
        end else begin
          c.rin     = 1'b1;
          c.rin_sel = f.ra;
        end
      end
      S_T6: begin
        c.src  = SRC_ZHIGH;
        c.hiin = 1'b1;
      end
      S_ERR:   c.err = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    fields_d = fields_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
`ifdef MEM_WAIT_EN
      S_T1:   if (mem_ready) state_d = S_T2;
`else
      S_T1:   state_d = S_T2;
`endif
      S_T2: begin
        state_d  = S_T3;
        fields_d = '{opcode: ir[31:27], ra: ir[26:23], rb: ir[22:19], rc: ir[18:15]};
      end
      S_T3:   state_d = is_legal(fields_q.opcode) ? S_T4 : S_ERR;
      S_T4:   state_d = S_T5;
      S_T5: begin
        if (is_muldiv(fields_q.opcode)) state_d = S_T6;
        else                            state_d = run ? S_T0 : S_IDLE;
      end
      S_T6:   state_d = run ? S_T0 : S_IDLE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    // Outputs are decoded from the state being entered, so they are registered yet Moore.
    ctrl_d = decode(state_d, fields_d);
  end

  always_ff @(posedge clock or posedge clear) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clear) begin
      state_q  <= S_IDLE;
      fields_q <= '0;
      ctrl_q   <= decode(S_IDLE, '0);
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign src_sel = ctrl_q.src;
  assign MARin   = ctrl_q.mar;
  assign IncPC   = ctrl_q.incpc;
  assign Read    = ctrl_q.read;
  assign MDRin   = ctrl_q.mdrin;
  assign IRin    = ctrl_q.irin;
  assign Yin     = ctrl_q.yin;
  assign Zin     = ctrl_q.zin;
  assign HIin    = ctrl_q.hiin;
  assign LOin    = ctrl_q.loin;
  assign Rin     = ctrl_q.rin;
  assign rin_sel = ctrl_q.rin_sel;
  assign alu_op  = ctrl_q.alu_op;
  assign busy    = ctrl_q.busy;
  assign err     = ctrl_q.err;

`ifdef MEM_WAIT_EN
  // PC may only update once, in the T1 cycle where the memory read completes.
  assign PCin = ctrl_q.pcin & mem_ready;
`else
  assign PCin = ctrl_q.pcin;
`endif

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Scoreboard bench for bus_control_sequencer: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares. Covers the MEM_WAIT_EN stretch when that macro is set.
module tb_bus_control_sequencer;

  typedef struct packed {
    logic [4:0]  src;
    logic [10:0] stb;   // {MARin,PCin,IncPC,Read,MDRin,IRin,Yin,Zin,HIin,LOin,Rin}
    logic [3:0]  rin_sel;
    logic [4:0]  alu_op;
    logic        busy;
    logic        err;
  } ovec_t;

  typedef struct {
    ovec_t v;
    string name;
  } exp_t;

  localparam logic [10:0] MAR = 11'b100_0000_0000;
  localparam logic [10:0] PCI = 11'b010_0000_0000;
  localparam logic [10:0] INC = 11'b001_0000_0000;
  localparam logic [10:0] RD  = 11'b000_1000_0000;
  localparam logic [10:0] MDR = 11'b000_0100_0000;
  localparam logic [10:0] IRI = 11'b000_0010_0000;
  localparam logic [10:0] YIN = 11'b000_0001_0000;
  localparam logic [10:0] ZIN = 11'b000_0000_1000;
  localparam logic [10:0] HII = 11'b000_0000_0100;
  localparam logic [10:0] LOI = 11'b000_0000_0010;
  localparam logic [10:0] RIN = 11'b000_0000_0001;

  logic        clock, clear, run;
  logic [31:0] ir;
  logic [4:0]  src_sel;
  logic        MARin, PCin, IncPC, Read, MDRin, IRin, Yin, Zin, HIin, LOin, Rin;
  logic [3:0]  rin_sel;
  logic [4:0]  alu_op;
  logic        busy, err;
`ifdef MEM_WAIT_EN
  logic        mem_ready;
`endif

  bus_control_sequencer dut (
    .clock   (clock),
    .clear   (clear),
    .run     (run),
    .ir      (ir),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .src_sel (src_sel),
    .MARin   (MARin),
    .PCin    (PCin),
    .IncPC   (IncPC),
    .Read    (Read),
    .MDRin   (MDRin),
    .IRin    (IRin),
    .Yin     (Yin),
    .Zin     (Zin),
    .HIin    (HIin),
    .LOin    (LOin),
    .Rin     (Rin),
    .rin_sel (rin_sel),
    .alu_op  (alu_op),
    .busy    (busy),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  ovec_t act;
  assign act = {src_sel, MARin, PCin, IncPC, Read, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
                rin_sel, alu_op, busy, err};

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  function automatic ovec_t mk(input logic [4:0] src, input logic [10:0] stb,
                               input logic [3:0] rs, input logic [4:0] alu,
                               input logic bz, input logic er);
    return '{src: src, stb: stb, rin_sel: rs, alu_op: alu, busy: bz, err: er};
  endfunction

  function automatic string fmt(input ovec_t x);
    return $sformatf("src=%0d stb=%b rin_sel=%0d alu_op=%0h busy=%b err=%b",
                     x.src, x.stb, x.rin_sel, x.alu_op, x.busy, x.err);
  endfunction

  task automatic check(input string name, input ovec_t got, input ovec_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: actual {%s} required {%s}", name, fmt(got), fmt(want));
    end
  endtask

  task automatic push(input string name, input ovec_t v);
    exp_t e;
    e.v    = v;
    e.name = name;
    sb.push_back(e);
  endtask

  function automatic ovec_t idle_v();
    return mk(5'd31, '0, 4'd0, 5'd0, 1'b0, 1'b0);
  endfunction

  function automatic ovec_t err_v();
    return mk(5'd31, '0, 4'd0, 5'd0, 1'b0, 1'b1);
  endfunction

  task automatic push_fetch(input string tag);
    push({tag, "_T0"}, mk(5'd20, MAR | INC | ZIN, 4'd0, 5'd0, 1'b1, 1'b0));
    push({tag, "_T1"}, mk(5'd19, PCI | RD | MDR, 4'd0, 5'd0, 1'b1, 1'b0));
    push({tag, "_T2"}, mk(5'd21, IRI, 4'd0, 5'd0, 1'b1, 1'b0));
  endtask

  // T3..T5/T6 with hand-supplied Rb, T4 source, opcode and Ra.
  task automatic push_exec(input string tag, input logic [4:0] rb, input logic [4:0] t4_src,
                           input logic [4:0] op, input logic [3:0] ra, input bit muldiv);
    push({tag, "_T3"}, mk(rb, YIN, 4'd0, 5'd0, 1'b1, 1'b0));
    push({tag, "_T4"}, mk(t4_src, ZIN, 4'd0, op, 1'b1, 1'b0));
    if (muldiv) begin
      push({tag, "_T5"}, mk(5'd19, LOI, 4'd0, 5'd0, 1'b1, 1'b0));
      push({tag, "_T6"}, mk(5'd18, HII, 4'd0, 5'd0, 1'b1, 1'b0));
    end else begin
      push({tag, "_T5"}, mk(5'd19, RIN, ra, 5'd0, 1'b1, 1'b0));
    end
  endtask

  task automatic start(input logic [31:0] ir_v);
    @(posedge clock);
    #1;
    ir  = ir_v;
    run = 1'b1;
  endtask

  task automatic drop_after(input int n);
    repeat (n) @(posedge clock);
    #1;
    run = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: actual %0d entries pending required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: the DUT presents a control word every cycle; compare whenever one is expected.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check(e.name, act, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual time limit reached required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    run   = 1'b0;
    ir    = '0;
`ifdef MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    repeat (2) @(posedge clock);
    #1;
    check("reset_idle", act, idle_v());
    clear = 1'b0;

    // add R1,R2,R3 twice back to back, run dropped after the second T0.
    start(32'h0091_8000);
    push("add_pre", idle_v());
    push_fetch("add1");
    push_exec("add1", 5'd2, 5'd3, 5'h00, 4'd1, 1'b0);
    push_fetch("add2");
    push_exec("add2", 5'd2, 5'd3, 5'h00, 4'd1, 1'b0);
    push("add_post", idle_v());
    drop_after(7);
    drain("add");

    // addi R4,R5,imm: Csign drives the bus in T4.
    start(32'h6228_0000);
    push("addi_pre", idle_v());
    push_fetch("addi");
    push_exec("addi", 5'd5, 5'd23, 5'h0C, 4'd4, 1'b0);
    push("addi_post", idle_v());
    drop_after(1);
    drain("addi");

    // not R15,R14 (opcode 0x0A, last R-type): Rc=13 on the bus in T4.
    start(32'h57F6_8000);
    push("not_pre", idle_v());
    push_fetch("not");
    push_exec("not", 5'd14, 5'd13, 5'h0A, 4'd15, 1'b0);
    push("not_post", idle_v());
    drop_after(1);
    drain("not");

    // mul R6,R7: seven cycles, LO then HI, no Rin.
    start(32'h7B38_0000);
    push("mul_pre", idle_v());
    push_fetch("mul");
    push_exec("mul", 5'd7, 5'd0, 5'h0F, 4'd0, 1'b1);
    push("mul_post", idle_v());
    drop_after(1);
    drain("mul");

    // div R2,R3 (opcode 0x10, highest legal).
    start(32'h8118_0000);
    push("div_pre", idle_v());
    push_fetch("div");
    push_exec("div", 5'd3, 5'd0, 5'h10, 4'd0, 1'b1);
    push("div_post", idle_v());
    drop_after(1);
    drain("div");

    // run dropped during T2: add still completes, then IDLE.
    start(32'h0091_8000);
    push("drop_pre", idle_v());
    push_fetch("drop");
    push_exec("drop", 5'd2, 5'd3, 5'h00, 4'd1, 1'b0);
    push("drop_post", idle_v());
    drop_after(3);
    drain("drop");

    // Asynchronous clear in the middle of T4.
    start(32'h0091_8000);
    push("clr_pre", idle_v());
    push_fetch("clr");
    push("clr_T3", mk(5'd2, YIN, 4'd0, 5'd0, 1'b1, 1'b0));
    repeat (5) @(posedge clock);
    #1;
    check("clr_in_T4", act, mk(5'd3, ZIN, 4'd0, 5'h00, 1'b1, 1'b0));
    clear = 1'b1;
    #1;
    check("clr_async", act, idle_v());
    #1;
    clear = 1'b0;
    @(posedge clock);
    #1;
    run = 1'b0;
    push_fetch("clr_rerun");
    push_exec("clr_rerun", 5'd2, 5'd3, 5'h00, 4'd1, 1'b0);
    push("clr_rerun_post", idle_v());
    drain("clr_rerun");

    // Illegal opcode 0x1F: no Yin in T3, sticky ERR ignoring run.
    start(32'hF800_0000);
    push("ill_pre", idle_v());
    push_fetch("ill");
    push("ill_T3", mk(5'd0, '0, 4'd0, 5'd0, 1'b1, 1'b0));
    push("ill_err", err_v());
    drop_after(1);
    drain("ill");
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      run = ~run;
      push("ill_err_hold", err_v());
    end
    drain("ill_hold");
    @(posedge clock);
    #1;
    clear = 1'b1;
    #1;
    check("ill_cleared", act, idle_v());
    clear = 1'b0;

`ifdef MEM_WAIT_EN
    // mem_ready low for three T1 cycles: T1 lasts four, PCin only in the last.
    start(32'h0091_8000);
    mem_ready = 1'b0;
    push("mw_pre", idle_v());
    push("mw_T0", mk(5'd20, MAR | INC | ZIN, 4'd0, 5'd0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) push("mw_T1_wait", mk(5'd19, RD | MDR, 4'd0, 5'd0, 1'b1, 1'b0));
    push("mw_T1_done", mk(5'd19, PCI | RD | MDR, 4'd0, 5'd0, 1'b1, 1'b0));
    push("mw_T2", mk(5'd21, IRI, 4'd0, 5'd0, 1'b1, 1'b0));
    push_exec("mw", 5'd2, 5'd3, 5'h00, 4'd1, 1'b0);
    push("mw_post", idle_v());
    drop_after(1);
    repeat (4) @(posedge clock);
    #1;
    mem_ready = 1'b1;
    drain("mw");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
